// File: rtl/half_adder_iter_ctrl_if.sv
// Operand/result handshake bundle for the iterative half-adder controller.
// The master side is the producer/consumer; the slave side is the controller.
interface half_adder_iter_ctrl_if #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  sum;
  logic          cout;
  logic [CW-1:0] iters;
  logic          busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, cout, iters, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, cout, iters, busy
  );
endinterface

// File: rtl/half_adder_iter_ctrl.sv
// Builds a full N-bit adder by re-applying a carry-free half-adder array
// until the carry vector drains to zero; operands and results use valid/ready.
module half_adder_iter_ctrl #(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  half_adder_iter_ctrl_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [N-1:0]  x;
  logic [N-1:0]  y;
  logic          cflag;
  logic [CW-1:0] count;

  logic [N-1:0]  sum_r;
  logic          cout_r;
  logic [CW-1:0] iters_r;

  logic [N-1:0]  ha_s;
  logic [N-1:0]  ha_c;
  logic          y_zero;

  logic          in_ready_c;
  logic          out_valid_c;
  logic          busy_c;

  // Bitwise half-adder array: no carry chain between bit positions.
  for (genvar i = 0; i < N; i++) begin : g_ha
    assign ha_s[i] = x[i] ^ y[i];
    assign ha_c[i] = x[i] & y[i];
  end

  assign y_zero = (y == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b1;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b0;
        if (bus.in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (y_zero) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Working registers and result registers; results persist until the next DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      y       <= '0;
      cflag   <= 1'b0;
      count   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      iters_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x     <= bus.a;
            y     <= bus.b;
            cflag <= 1'b0;
            count <= '0;
          end
        end
        RUN: begin
          if (y_zero) begin
            sum_r   <= x;
            cout_r  <= cflag;
            iters_r <= count;
          end else begin
            x     <= ha_s;
            // The carry leaving bit N-1 is folded into the flag, never wrapped back.
            y     <= {ha_c[N-2:0], 1'b0};
            cflag <= cflag | ha_c[N-1];
            count <= count + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // The carry vector gains a trailing zero per update, so N updates always suffice.
  always @(posedge clk) begin
    if (rst_n && (state == RUN) && !y_zero) begin
      assert (count < CW'(N))
        else $error("half_adder_iter_ctrl: update %0d exceeds N=%0d", count + 1, N);
    end
  end
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.iters     = iters_r;

endmodule
